ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 command transmitter for the mouse port (PS2_CLK1/PS2_DATA1).
//  On a send request it holds clock low for the inhibit period and drives the start bit.
//  It then shifts one byte, odd parity and stop on device-generated clock edges, and checks the device ACK.
//  Output side is open-drain enables only; the top level ties the pin to 0 when *_oe=1, else 1'bz.
// PARAMETERS
//  INHIBIT_CYCLES  5000     qzt_clk cycles PS2 clock held low (100 us @ 50 MHz)
//  RTS_CYCLES      100      cycles data held low before clock released (2 us)
//  TIMEOUT_CYCLES  750000   max cycles waiting for any device clock edge (15 ms)
// PORTS
//  qzt_clk      in   1  50 MHz system clock
//  reset_n      in   1  asynchronous active-low reset
//  tx_data      in   8  command byte, sampled on accepted send
//  send         in   1  request; accepted only in IDLE, single-cycle pulse sufficient
//  ps2_clk_in   in   1  raw PS2 clock pin level (async)
//  ps2_data_in  in   1  raw PS2 data pin level (async)
//  ps2_clk_oe   out  1  1 = pull PS2 clock low
//  ps2_data_oe  out  1  1 = pull PS2 data low
//  busy         out  1  high from accepted send until return to IDLE
//  done         out  1  1-cycle pulse: frame finished with ACK
//  err          out  1  1-cycle pulse: NACK or timeout; coincident with done=0
// BEHAVIOUR
//  - Reset (async, immediate): both oe=0, busy=0, done=0, err=0, state IDLE, sync regs=1.
//  - Pins are passed through a 2-FF synchronizer; falling edge = sync_prev&~sync.
//  - Pin-to-data latency: ps2_data_oe updates 3 qzt_clk cycles after a pin falling edge.
//  - IDLE: send=1 -> latch tx_data, parity=~^tx_data (odd), busy=1 next cycle -> INHIBIT.
//  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES -> RTS.
//  - RTS: data_oe=1 (start bit 0), clk_oe=1 for RTS_CYCLES -> clk_oe=0 -> SHIFT.
//  - SHIFT: on falling edges n=1..8 drive bit n-1 (LSB first); n=9 parity.
//    On n=10, release data (stop=1) -> ACK.
//    data_oe=~bit (drive low for 0, release for 1).
//  - ACK: on falling edge 11 sample data: 0 = ACK, 1 = NACK -> WAIT_IDLE.
//  - WAIT_IDLE: wait sync clk=1 and data=1, then pulse done (ACK) or err (NACK) -> IDLE.
//  - Timeout counter reloads on every falling edge and on entry to SHIFT.
//    Expiry in SHIFT/ACK/WAIT_IDLE: release both lines, pulse err, go to IDLE.
//  - send while busy: ignored, no queuing; tx_data changes after acceptance have no effect.
//  - done and err are never asserted together; busy falls in the same cycle as the pulse.
//  - Counters sized by $clog2 of their parameter; no wrap: they saturate at limit and are reloaded on entry.
// CONFIGURATION
//  `ACK_RETRY_EN defined:
//    - On NACK or timeout, restart once from INHIBIT with the same byte; busy stays high.
//    - err pulses only if the retry also fails; done if the retry succeeds.
//  Undefined: no retry; the first NACK or timeout pulses err.
// TESTING
//  1. tx_data=8'hF4, send; device model clocks 11 edges, ACK low
//     -> data bits 0,0,1,0,1,1,1,1, parity 0, stop released, done=1 x1 cycle.
//  2. tx_data=8'hFF -> parity bit 1 (data released on edge 9), done pulse.
//  3. Device NACKs (data high on edge 11) -> err pulse, no done; with ACK_RETRY_EN, a second INHIBIT of 5000 cycles occurs first.
//  4. Device stops clocking after edge 4 -> err exactly 750000 cycles after edge 4, both oe=0.
//  5. reset_n low mid-SHIFT (edge 5) -> oe=0, busy=0 without a clock edge; new send afterwards completes normally.
//  6. send pulsed again during INHIBIT with 8'h00 -> ignored, frame carries the original byte; clk_oe low exactly 5000 cycles.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_host_tx                                                |
// | Description : Host-to-device PS/2 command transmitter (mouse port).      |
// |               Inhibits the clock, issues request-to-send, shifts a byte  |
// |               with odd parity and stop on device clock edges, then       |
// |               checks the device ACK. Drives open-drain enables only.     |
// | Options     : define ACK_RETRY_EN to retry once on NACK or timeout.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       qzt_clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       send,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef ACK_RETRY_EN
    localparam logic c_RETRY_EN = 1'b1;
`else
    localparam logic c_RETRY_EN = 1'b0;
`endif

    // One phase counter serves both the inhibit and the request-to-send hold
    localparam int c_PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_PH_W-1:0] c_INH_LAST = c_PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_RTS_LAST = c_PH_W'(RTS_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INHIBIT   = 3'd1;
    localparam logic [2:0] c_RTS       = 3'd2;
    localparam logic [2:0] c_SHIFT     = 3'd3;
    localparam logic [2:0] c_ACK       = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    // Pin synchronizers and falling-edge history
    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_data_meta, r_data_sync;
    logic w_clk_fall;

    // FSM and datapath registers with their next-state values
    logic [2:0]        r_state,   w_state_nxt;
    logic [c_PH_W-1:0] r_ph,      w_ph_nxt;
    logic [c_TO_W-1:0] r_to,      w_to_nxt;
    logic [7:0]        r_byte,    w_byte_nxt;
    logic [9:0]        r_shift,   w_shift_nxt;
    logic [3:0]        r_edge,    w_edge_nxt;
    logic              r_data_oe, w_data_oe_nxt;
    logic              r_nack,    w_nack_nxt;
    logic              r_retry,   w_retry_nxt;
    logic              r_done,    w_done_nxt;
    logic              r_err,     w_err_nxt;
    logic              w_to_exp;
    logic              w_fail;
    logic              w_ok;

    assign w_clk_fall = r_clk_prev & ~r_clk_sync;
    assign w_to_exp   = (r_to == c_TO_LAST) && !w_clk_fall;

    // Two-stage synchronizers; idle lines read as high out of reset
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    // State and datapath register
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_ph      <= '0;
            r_to      <= '0;
            r_byte    <= '0;
            r_shift   <= '1;
            r_edge    <= '0;
            r_data_oe <= 1'b0;
            r_nack    <= 1'b0;
            r_retry   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_to      <= w_to_nxt;
            r_byte    <= w_byte_nxt;
            r_shift   <= w_shift_nxt;
            r_edge    <= w_edge_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_nack    <= w_nack_nxt;
            r_retry   <= w_retry_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state logic: sequencing, bit shifting, ACK check, timeout and retry
    always_comb begin
        w_state_nxt   = r_state;
        w_ph_nxt      = r_ph;
        w_byte_nxt    = r_byte;
        w_shift_nxt   = r_shift;
        w_edge_nxt    = r_edge;
        w_data_oe_nxt = r_data_oe;
        w_nack_nxt    = r_nack;
        w_retry_nxt   = r_retry;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_fail        = 1'b0;
        w_ok          = 1'b0;

        // Timeout reloads on every device edge and saturates at its limit
        if (w_clk_fall) begin
            w_to_nxt = '0;
        end else if (r_to != c_TO_LAST) begin
            w_to_nxt = r_to + c_TO_W'(1);
        end else begin
            w_to_nxt = r_to;
        end

        case (r_state)
            c_IDLE: begin
                if (send) begin
                    w_byte_nxt  = tx_data;
                    w_ph_nxt    = '0;
                    w_retry_nxt = 1'b0;
                    w_state_nxt = c_INHIBIT;
                end
            end
            c_INHIBIT: begin
                if (r_ph == c_INH_LAST) begin
                    w_ph_nxt      = '0;
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = c_RTS;
                end else begin
                    w_ph_nxt = r_ph + c_PH_W'(1);
                end
            end
            c_RTS: begin
                if (r_ph == c_RTS_LAST) begin
                    w_ph_nxt    = '0;
                    w_to_nxt    = '0;
                    w_edge_nxt  = '0;
                    // Stop, odd parity, then data LSB first
                    w_shift_nxt = {1'b1, ~^r_byte, r_byte};
                    w_state_nxt = c_SHIFT;
                end else begin
                    w_ph_nxt = r_ph + c_PH_W'(1);
                end
            end
            c_SHIFT: begin
                if (w_clk_fall) begin
                    // Edge 10 shifts out the stop bit, which releases the line
                    w_data_oe_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b1, r_shift[9:1]};
                    w_edge_nxt    = r_edge + 4'd1;
                    if (r_edge == 4'd9) begin
                        w_state_nxt = c_ACK;
                    end
                end else if (w_to_exp) begin
                    w_fail = 1'b1;
                end
            end
            c_ACK: begin
                if (w_clk_fall) begin
                    w_nack_nxt  = r_data_sync;
                    w_state_nxt = c_WAIT_IDLE;
                end else if (w_to_exp) begin
                    w_fail = 1'b1;
                end
            end
            c_WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    if (r_nack) begin
                        w_fail = 1'b1;
                    end else begin
                        w_ok = 1'b1;
                    end
                end else if (w_to_exp) begin
                    w_fail = 1'b1;
                end
            end
            default: begin
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = c_IDLE;
            end
        endcase

        if (w_ok) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = c_IDLE;
        end

        // Failure releases both lines; one retry of the same byte when enabled
        if (w_fail) begin
            w_data_oe_nxt = 1'b0;
            if (c_RETRY_EN && !r_retry) begin
                w_retry_nxt = 1'b1;
                w_ph_nxt    = '0;
                w_state_nxt = c_INHIBIT;
            end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = c_IDLE;
            end
        end
    end

    assign ps2_clk_oe  = (r_state == c_INHIBIT) || (r_state == c_RTS);
    assign ps2_data_oe = r_data_oe;
    assign busy        = (r_state != c_IDLE);
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ps2_host_tx                                             |
// | Description : Scoreboard bench for ps2_host_tx with a PS/2 device model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int RTS  = 8;
    localparam int TMO  = 1500;
    localparam int HALF = 12;

    logic       qzt_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       send    = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       line_clk, line_data;

    logic       dev_clk_high = 1'b1;
    logic       dev_data_low = 1'b0;
    bit         dev_nack = 1'b0;
    int         dev_stall_after = 11;
    bit         dev_active = 1'b0;
    int         dev_edges = 0;
    int         last_edge_cyc = 0;
    logic [9:0] rx_frame = '1;
    logic       rx_start = 1'b1;
    logic [9:0] last_frame = '1;
    logic       last_start = 1'b1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         is_err;
        bit         chk_frame;
        logic [9:0] frame;
        bit         chk_time;
    } exp_t;
    exp_t sbq[$];

    assign line_clk  = ~ps2_clk_oe & dev_clk_high;
    assign line_data = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .qzt_clk    (qzt_clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .send       (send),
        .ps2_clk_in (line_clk),
        .ps2_data_in(line_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #10 qzt_clk = ~qzt_clk;

    initial forever begin
        @(posedge qzt_clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: data LSB first, odd parity over the byte, stop = 1
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) ones++;
        end
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    // PS/2 device: waits for request-to-send, then clocks the frame in
    initial forever begin
        @(negedge qzt_clk);
        if (reset_n && ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) begin
            dev_active = 1'b1;
            while (ps2_clk_oe === 1'b1) @(negedge qzt_clk);
            rx_start  = line_data;
            rx_frame  = '1;
            dev_edges = 0;
            for (int n = 1; n <= 11; n++) begin
                if (n > dev_stall_after) break;
                repeat (HALF) @(negedge qzt_clk);
                if (n == 11 && !dev_nack) dev_data_low = 1'b1;
                repeat (2) @(negedge qzt_clk);
                dev_clk_high  = 1'b0;
                dev_edges++;
                last_edge_cyc = cyc;
                repeat (HALF) @(negedge qzt_clk);
                if (n <= 10) rx_frame[n-1] = line_data;
                dev_clk_high = 1'b1;
                if (n == 11) dev_data_low = 1'b0;
            end
            last_frame = rx_frame;
            last_start = rx_start;
            dev_active = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every done/err pulse
    initial begin
        bit   prev_pulse = 1'b0;
        exp_t e;
        forever begin
            @(negedge qzt_clk);
            if (!reset_n) begin
                prev_pulse = 1'b0;
            end else begin
                if (done === 1'b1 && err === 1'b1) chk("done_err_together", 1, 0);
                if (done === 1'b1 || err === 1'b1) begin
                    chk("pulse_width", prev_pulse, 0);
                    chk("busy_at_pulse", busy, 0);
                    chk("oe_at_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", done, err);
                    end else begin
                        e = sbq.pop_front();
                        chk("outcome_err", err, e.is_err);
                        if (e.chk_frame) begin
                            chk("start_bit", last_start, 0);
                            chk("frame", last_frame, e.frame);
                        end
                        if (e.chk_time) chk("timeout_cycle", cyc, last_edge_cyc + TMO + 3);
                    end
                end
                prev_pulse = (done === 1'b1) || (err === 1'b1);
            end
        end
    end

    // Phase monitor: inhibit and request-to-send durations
    initial begin
        int ph;
        int prev_ph = 0;
        int run = 0;
        forever begin
            @(negedge qzt_clk);
            if (!reset_n) begin
                prev_ph = 0;
                run     = 0;
            end else begin
                ph = (ps2_clk_oe === 1'b1) ? ((ps2_data_oe === 1'b1) ? 2 : 1) : 0;
                if (ph != prev_ph) begin
                    if (prev_ph == 1) chk("inhibit_len", run, INH);
                    if (prev_ph == 2) chk("rts_len", run, RTS);
                    run = 1;
                end else begin
                    run++;
                end
                prev_ph = ph;
            end
        end
    end

    task automatic wait_quiet();
        bit ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge qzt_clk);
            if (busy === 1'b0 && !dev_active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        repeat (4) @(negedge qzt_clk);
    endtask

    task automatic run_txn(input logic [7:0] b, input bit nack, input int stall, input bit resend);
        exp_t e;
        wait_quiet();
        dev_nack        = nack;
        dev_stall_after = stall;
        e.is_err    = nack || (stall < 11);
        e.chk_frame = (stall >= 11);
        e.frame     = model_frame(b);
        e.chk_time  = (stall < 11);
        sbq.push_back(e);
        @(negedge qzt_clk);
        tx_data = b;
        send    = 1'b1;
        @(negedge qzt_clk);
        send    = 1'b0;
        tx_data = ~b;
        if (resend) begin
            repeat (5) @(negedge qzt_clk);
            tx_data = 8'h00;
            send    = 1'b1;
            @(negedge qzt_clk);
            send    = 1'b0;
        end
        wait_quiet();
    endtask

    initial begin
        #1800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge qzt_clk);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge qzt_clk);

        run_txn(8'hF4, 1'b0, 11, 1'b0);
        run_txn(8'hFF, 1'b0, 11, 1'b0);
        run_txn(8'hA5, 1'b1, 11, 1'b0);
        run_txn(8'h3C, 1'b0, 4, 1'b0);
        run_txn(8'h96, 1'b0, 11, 1'b1);

        // Asynchronous reset in the middle of the data bits
        wait_quiet();
        dev_nack        = 1'b0;
        dev_stall_after = 11;
        @(negedge qzt_clk);
        tx_data = 8'h5A;
        send    = 1'b1;
        @(negedge qzt_clk);
        send = 1'b0;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                @(negedge qzt_clk);
                if (dev_active && dev_edges >= 5) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reached_edge5", hit, 1);
        end
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 0);
        chk("async_rst_data_oe", ps2_data_oe, 0);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge qzt_clk);
        reset_n = 1'b1;
        wait_quiet();
        run_txn(8'hC3, 1'b0, 11, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_txn(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                    11, 1'($urandom_range(0, 1)));
        end

        wait_quiet();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
